// File: rtl/wht_dc_merge_if.sv
// Handshake bundle between the inverse WHT / AC coefficient source and the
// DC merge block; the merge block sits on the slave side.
interface wht_dc_merge_if #(
    parameter int COEF_W = 16
) ();
    localparam int BLK_W = COEF_W * 16;

    logic             mb_start;
    logic             has_y2;
    logic             dc_valid;
    logic [BLK_W-1:0] dc_data;
    logic             ac_valid;
    logic             ac_ready;
    logic [BLK_W-1:0] ac_data;
    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] blk_data;
    logic [3:0]       blk_idx;
    logic             blk_last;
    logic             mb_done;
    logic             dc_overrun;

    modport slave (
        input  mb_start, has_y2, dc_valid, dc_data, ac_valid, ac_data, blk_ready,
        output ac_ready, blk_valid, blk_data, blk_idx, blk_last, mb_done, dc_overrun
    );

    modport master (
        output mb_start, has_y2, dc_valid, dc_data, ac_valid, ac_data, blk_ready,
        input  ac_ready, blk_valid, blk_data, blk_idx, blk_last, mb_done, dc_overrun
    );
endinterface

// File: rtl/wht_dc_merge.sv
// Buffers the 16 luma DC values from the inverse WHT and substitutes them into
// lane 0 of each 4x4 AC block on its way to the per-block inverse transform.
module wht_dc_merge #(
    parameter int COEF_W = 16,
    parameter int NBLK   = 16,
    parameter int BLK_W  = COEF_W * 16
) (
    input  logic          clk,
    input  logic          rst_n,
    wht_dc_merge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DC = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic                         mode_q, mode_d;
    logic                         dc_full_q, dc_full_d;
    logic [NBLK-1:0][COEF_W-1:0]  dc_buf_q, dc_buf_d;
    logic [3:0]                   blk_cnt_q, blk_cnt_d;
    logic                         blk_valid_q, blk_valid_d;
    logic [BLK_W-1:0]             blk_data_q, blk_data_d;
    logic [3:0]                   blk_idx_q, blk_idx_d;
    logic                         blk_last_q, blk_last_d;
    logic                         mb_done_q, mb_done_d;
    logic                         dc_overrun_q, dc_overrun_d;

    logic ac_ready;
    logic accept;
    logic out_fire;

    // Single output register: a new beat may enter whenever the slot is empty
    // or is being emptied in the same cycle, so continuous flow has no bubble.
    assign ac_ready = (state_q == STREAM) && (!blk_valid_q || bus.blk_ready);
    assign accept   = bus.ac_valid && ac_ready;
    assign out_fire = blk_valid_q && bus.blk_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so that no
        // path through the branches below leaves one unassigned (no latches).
        state_d      = state_q;
        mode_d       = mode_q;
        dc_full_d    = dc_full_q;
        dc_buf_d     = dc_buf_q;
        blk_cnt_d    = blk_cnt_q;
        blk_valid_d  = blk_valid_q;
        blk_data_d   = blk_data_q;
        blk_idx_d    = blk_idx_q;
        blk_last_d   = blk_last_q;
        mb_done_d    = 1'b0;
        dc_overrun_d = dc_overrun_q;

        // DC may land before mb_start and is kept; once streaming it is lost.
        if (bus.dc_valid) begin
            if (state_q == IDLE || state_q == WAIT_DC) begin
                dc_buf_d  = bus.dc_data;
                dc_full_d = 1'b1;
            end else begin
                dc_overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.mb_start) begin
                    mode_d = bus.has_y2;
                    if (bus.has_y2 && !dc_full_q && !bus.dc_valid) begin
                        state_d = WAIT_DC;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            WAIT_DC: begin
                if (bus.dc_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && blk_cnt_q == 4'd15) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && blk_last_q) begin
                    state_d   = IDLE;
                    mb_done_d = 1'b1;
                    if (mode_q) begin
                        dc_full_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            blk_cnt_d              = blk_cnt_q + 4'd1;
            blk_valid_d            = 1'b1;
            blk_data_d             = bus.ac_data;
            blk_data_d[COEF_W-1:0] = mode_q ? dc_buf_q[blk_cnt_q] : bus.ac_data[COEF_W-1:0];
            blk_idx_d              = blk_cnt_q;
            blk_last_d             = (blk_cnt_q == 4'd15);
        end else if (out_fire) begin
            blk_valid_d = 1'b0;
        end
    end

    // NOTE: state registers take non-blocking assignments only; the comb
    // process above is the one place blocking assignments belong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            dc_full_q    <= 1'b0;
            // NOTE: the DC buffer is reset too, so a macroblock aborted by
            // reset can never leak stale DC values into the next one.
            dc_buf_q     <= '0;
            blk_cnt_q    <= 4'd0;
            blk_valid_q  <= 1'b0;
            blk_data_q   <= '0;
            blk_idx_q    <= 4'd0;
            blk_last_q   <= 1'b0;
            mb_done_q    <= 1'b0;
            dc_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dc_full_q    <= dc_full_d;
            dc_buf_q     <= dc_buf_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_valid_q  <= blk_valid_d;
            blk_data_q   <= blk_data_d;
            blk_idx_q    <= blk_idx_d;
            blk_last_q   <= blk_last_d;
            mb_done_q    <= mb_done_d;
            dc_overrun_q <= dc_overrun_d;
        end
    end

    assign bus.ac_ready   = ac_ready;
    assign bus.blk_valid  = blk_valid_q;
    assign bus.blk_data   = blk_data_q;
    assign bus.blk_idx    = blk_idx_q;
    assign bus.blk_last   = blk_last_q;
    assign bus.mb_done    = mb_done_q;
    assign bus.dc_overrun = dc_overrun_q;

endmodule

// File: tb/tb_wht_dc_merge.sv
// Directed bench for wht_dc_merge: merge, bypass, late DC, backpressure,
// early DC with overrun, and reset mid-macroblock.
module tb_wht_dc_merge;

    logic clk;
    logic rst_n;
    int   cyc;

    wht_dc_merge_if bus ();

    wht_dc_merge dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests;
    int n_fail;

    logic [255:0] q_data[$];
    logic [3:0]   q_idx[$];
    logic         q_last[$];
    int           q_cyc[$];
    int           done_cnt;
    int           done_cyc;
    int           stall_cnt;
    logic [255:0] exp_blk[16];
    bit           bp_mode;
    int           bp_pat[4] = '{1, 0, 0, 1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_blk(input logic [15:0] l0, input logic [15:0] rest);
        logic [255:0] r;
        for (int k = 1; k < 16; k++) r[16*k +: 16] = rest;
        r[15:0] = l0;
        return r;
    endfunction

    function automatic logic [255:0] mk_dc(input logic [15:0] base, input logic [15:0] step);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[16*k +: 16] = base + 16'(k) * step;
        return r;
    endfunction

    // Downstream ready: always 1, or the 1,0,0,1 pattern during backpressure.
    initial begin
        int bp_i;
        bp_i = 0;
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.blk_ready = (bp_pat[bp_i % 4] != 0);
                bp_i++;
            end else begin
                bus.blk_ready = 1'b1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.blk_valid && bus.blk_ready) begin
                    q_data.push_back(bus.blk_data);
                    q_idx.push_back(bus.blk_idx);
                    q_last.push_back(bus.blk_last);
                    q_cyc.push_back(cyc);
                end
                if (bus.blk_valid && !bus.blk_ready) begin
                    stall_cnt++;
                    check("stall_ac_ready", 256'(bus.ac_ready), 256'(0));
                end
                if (bus.mb_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        q_cyc.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        stall_cnt = 0;
    endtask

    task automatic mb(input logic y2);
        bus.mb_start = 1'b1;
        bus.has_y2   = y2;
        tick();
        bus.mb_start = 1'b0;
        bus.has_y2   = 1'b0;
    endtask

    task automatic dc_pulse(input logic [255:0] d);
        bus.dc_valid = 1'b1;
        bus.dc_data  = d;
        tick();
        bus.dc_valid = 1'b0;
    endtask

    // Consumes one cycle: checks ac_ready on the falling edge.
    task automatic peek_ready(input string tag, input logic exp);
        @(negedge clk);
        check(tag, 256'(bus.ac_ready), 256'(exp));
        tick();
    endtask

    // Must be entered just after a rising edge; returns just after the accepting edge.
    task automatic send_ac(input logic [255:0] d);
        int n;
        bus.ac_valid = 1'b1;
        bus.ac_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.ac_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ac_accept_timeout", 256'(n), 256'(0));
        tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt < 1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("mb_done_timeout", 256'(done_cnt), 256'(1));
        repeat (3) tick();
    endtask

    task automatic verify_stream(input string tag, input bit contiguous);
        check({tag, "_count"}, 256'(q_data.size()), 256'(16));
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            check($sformatf("%s_idx%0d", tag, i), 256'(q_idx[i]), 256'(i));
            check($sformatf("%s_data%0d", tag, i), q_data[i], exp_blk[i]);
            check($sformatf("%s_last%0d", tag, i), 256'(q_last[i]), 256'(i == 15));
            if (contiguous && i > 0)
                check($sformatf("%s_gap%0d", tag, i), 256'(q_cyc[i] - q_cyc[i-1]), 256'(1));
        end
        check({tag, "_done_cnt"}, 256'(done_cnt), 256'(1));
        if (q_cyc.size() > 0)
            check({tag, "_done_lat"}, 256'(done_cyc - q_cyc[q_cyc.size()-1]), 256'(1));
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        bp_mode      = 1'b0;
        rst_n        = 1'b0;
        bus.mb_start = 1'b0;
        bus.has_y2   = 1'b0;
        bus.dc_valid = 1'b0;
        bus.dc_data  = '0;
        bus.ac_valid = 1'b0;
        bus.ac_data  = '0;
        clear_mon();
        repeat (2) tick();

        check("rst_blk_valid", 256'(bus.blk_valid), 256'(0));
        check("rst_blk_data", bus.blk_data, 256'(0));
        check("rst_ac_ready", 256'(bus.ac_ready), 256'(0));
        check("rst_mb_done", 256'(bus.mb_done), 256'(0));
        check("rst_overrun", 256'(bus.dc_overrun), 256'(0));
        rst_n = 1'b1;
        tick();

        // Merge: DC lanes 100+k, AC lanes all 5, no backpressure.
        clear_mon();
        mb(1'b1);
        dc_pulse(mk_dc(16'd100, 16'd1));
        for (int i = 0; i < 16; i++) send_ac(mk_blk(16'h0005, 16'h0005));
        bus.ac_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'(100 + i), 16'h0005);
        verify_stream("merge", 1'b1);

        // Bypass: lane 0 = -3 passes through, no WAIT_DC.
        clear_mon();
        mb(1'b0);
        peek_ready("bypass_no_wait", 1'b1);
        for (int i = 0; i < 16; i++) send_ac(mk_blk(16'hFFFD, 16'h0042));
        bus.ac_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'hFFFD, 16'h0042);
        verify_stream("bypass", 1'b1);

        // Late DC: AC waits while DC is outstanding.
        clear_mon();
        mb(1'b1);
        bus.ac_valid = 1'b1;
        bus.ac_data  = mk_blk(16'h1234, 16'h0777);
        for (int i = 0; i < 4; i++) peek_ready("late_wait", 1'b0);
        bus.dc_valid = 1'b1;
        bus.dc_data  = mk_dc(16'h1000, 16'd1);
        @(negedge clk);
        check("late_capture_cycle", 256'(bus.ac_ready), 256'(0));
        tick();
        bus.dc_valid = 1'b0;
        @(negedge clk);
        check("late_ready_after", 256'(bus.ac_ready), 256'(1));
        tick();
        for (int i = 1; i < 16; i++) send_ac(mk_blk(16'h1234, 16'h0777));
        bus.ac_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'(16'h1000 + i), 16'h0777);
        verify_stream("late", 1'b1);

        // Backpressure 1,0,0,1 with DC lane k = -k; mb_start and DC together.
        clear_mon();
        bp_mode      = 1'b1;
        bus.mb_start = 1'b1;
        bus.has_y2   = 1'b1;
        bus.dc_valid = 1'b1;
        bus.dc_data  = mk_dc(16'h0000, 16'hFFFF);
        tick();
        bus.mb_start = 1'b0;
        bus.has_y2   = 1'b0;
        bus.dc_valid = 1'b0;
        peek_ready("bp_direct_stream", 1'b1);
        for (int i = 0; i < 16; i++) send_ac(mk_blk(16'(16'h0200 + i), 16'(16'h0200 + i)));
        bus.ac_valid = 1'b0;
        wait_done();
        bp_mode = 1'b0;
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'(0 - i), 16'(16'h0200 + i));
        verify_stream("bp", 1'b0);
        check("bp_stalls_seen", 256'(stall_cnt > 0), 256'(1));

        // Early DC in IDLE, then overrun mid-stream.
        clear_mon();
        check("early_overrun_clear", 256'(bus.dc_overrun), 256'(0));
        dc_pulse(mk_blk(16'h7FFF, 16'h7FFF));
        mb(1'b1);
        peek_ready("early_direct_stream", 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                bus.dc_valid = 1'b1;
                bus.dc_data  = mk_blk(16'h1111, 16'h1111);
            end
            send_ac(mk_blk(16'(16'h0050 + i), 16'h0060));
            bus.dc_valid = 1'b0;
        end
        bus.ac_valid = 1'b0;
        check("early_overrun_set", 256'(bus.dc_overrun), 256'(1));
        wait_done();
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'h7FFF, 16'h0060);
        verify_stream("early", 1'b1);

        // Reset after 7 outputs, then a fresh macroblock needing a new DC.
        clear_mon();
        mb(1'b1);
        dc_pulse(mk_dc(16'h2000, 16'd1));
        for (int i = 0; i < 8; i++) send_ac(mk_blk(16'h0000, 16'h0888));
        bus.ac_valid = 1'b0;
        check("rst_mid_outputs_before", 256'(q_data.size()), 256'(7));
        rst_n = 1'b0;
        #1;
        check("rst_mid_blk_valid", 256'(bus.blk_valid), 256'(0));
        check("rst_mid_blk_data", bus.blk_data, 256'(0));
        check("rst_mid_blk_idx", 256'(bus.blk_idx), 256'(0));
        check("rst_mid_blk_last", 256'(bus.blk_last), 256'(0));
        check("rst_mid_mb_done", 256'(bus.mb_done), 256'(0));
        check("rst_mid_overrun", 256'(bus.dc_overrun), 256'(0));
        check("rst_mid_ac_ready", 256'(bus.ac_ready), 256'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        mb(1'b1);
        for (int i = 0; i < 3; i++) peek_ready("post_rst_wait_dc", 1'b0);
        dc_pulse(mk_dc(16'h3000, 16'd1));
        for (int i = 0; i < 16; i++) send_ac(mk_blk(16'hAAAA, 16'h0999));
        bus.ac_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 16; i++) exp_blk[i] = mk_blk(16'(16'h3000 + i), 16'h0999);
        verify_stream("post_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
